ped_btn_conditioner: RTL and testbench

//  Upstream stage of the traffic-light controller; drives that controller's ped_btn input.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/ped_btn_conditioner_if.sv | 35 +++
 rtl/ped_btn_conditioner_btn_debounce.sv | 96 +++++++++
 rtl/ped_btn_conditioner.sv | 95 +++++++++
 tb/tb_ped_btn_conditioner.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: encodings shared by the traffic-light controller and its
// upstream stages.
//   main_light_t : main road lamp encoding (GREEN/YELLOW/RED)
//   PED_RED/PED_GREEN : pedestrian lamp levels
//   deb_state_t  : push-button debounce FSM states
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b10
   } main_light_t;

   localparam logic PED_RED   = 1'b0;
   localparam logic PED_GREEN = 1'b1;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      PRESS_CHK = 2'b01,
      PRESSED   = 2'b10,
      REL_CHK   = 2'b11
   } deb_state_t;

endpackage

// File: rtl/ped_btn_conditioner_if.sv
// ped_btn_conditioner_if: signals between the pedestrian button conditioner
// and its surroundings (button, traffic-light controller, WAIT lamp).
//   btn_raw     : raw bouncy button level, 1 = pressed
//   ped_light   : controller pedestrian lamp, 0 = red, 1 = green
//   ped_btn     : request level to the controller
//   press_pulse : one-cycle strobe per debounced press
//   wait_lamp   : WAIT indicator, same level as ped_btn
//   req_timeout : one-cycle strobe when a pending request is auto-cleared
//   deb_state   : debounce FSM state, observation only
// Request protocol: ped_btn is a level, not a pulse. It rises the cycle after
// an accepted press while ped_light is red and stays high until the cycle
// after ped_light rises to green (the controller serving it), or until a
// timeout when that option is built in.
// master = conditioner side, slave = environment side.
interface ped_btn_conditioner_if;
   import traffic_pkg::*;

   logic       btn_raw;
   logic       ped_light;
   logic       ped_btn;
   logic       press_pulse;
   logic       wait_lamp;
   logic       req_timeout;
   deb_state_t deb_state;

   modport master (
      input  btn_raw, ped_light,
      output ped_btn, press_pulse, wait_lamp, req_timeout, deb_state
   );

   modport slave (
      output btn_raw, ped_light,
      input  ped_btn, press_pulse, wait_lamp, req_timeout, deb_state
   );
endinterface

// File: rtl/ped_btn_conditioner_btn_debounce.sv
// btn_debounce: two-flop synchroniser plus debounce FSM for a push-button.
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_raw     : raw asynchronous button level
//   btn_s       : synchronised button level
//   press_pulse : one-cycle strobe when a press has been stable DEB_CYCLES
//   state       : current debounce state, observation only
// press_pulse is decoded from the final PRESS_CHK cycle so it appears in the
// same cycle the FSM commits to PRESSED.
module btn_debounce
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_raw,
   output logic       btn_s,
   output logic       press_pulse,
   output deb_state_t state
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Plain shift: nothing between the two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], btn_raw};
      end
   end

   assign btn_s = sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      press_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = PRESSED;
               press_pulse = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = REL_CHK;
               cnt_d   = '0;
            end
         end
         REL_CHK: begin
            // Bounce back to pressed re-enters PRESSED silently.
            if (btn_s) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: rtl/ped_btn_conditioner.sv
// ped_btn_conditioner: conditions the pedestrian push-button for the
// traffic-light controller. Synchronises and debounces the button and latches
// a request that is held until the controller turns the pedestrian lamp green.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ped_btn_conditioner_if.master (btn_raw, ped_light in;
//                ped_btn, press_pulse, wait_lamp, req_timeout, deb_state out)
// Build option PED_REQ_TIMEOUT_EN: a pending request is dropped after
// REQ_TIMEOUT cycles without service and req_timeout strobes once. Without it
// requests wait indefinitely and req_timeout is 0.
module ped_btn_conditioner
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES  = 16,
   parameter int REQ_TIMEOUT = 64
) (
   input logic                    clk,
   input logic                    rst_n,
   ped_btn_conditioner_if.master  bus
);

   logic       btn_s;
   logic       press;
   deb_state_t deb_state;
   logic       ped_light_q;
   logic       req_pending;
   logic       serve;
   logic       timeout_hit;
   logic       unused_bits;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (bus.btn_raw),
      .btn_s       (btn_s),
      .press_pulse (press),
      .state       (deb_state)
   );

   // Service is the red-to-green transition of the pedestrian lamp.
   assign serve = (bus.ped_light == PED_GREEN) && (ped_light_q == PED_RED);

`ifdef PED_REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(REQ_TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              req_timeout_q;

   // Serve takes precedence, so a timeout never strobes in a serve cycle.
   assign timeout_hit = req_pending && !serve &&
                        (wait_cnt == WAIT_W'(REQ_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt      <= '0;
         req_timeout_q <= 1'b0;
      end else begin
         req_timeout_q <= timeout_hit;
         if (!req_pending || serve || timeout_hit) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

   assign bus.req_timeout = req_timeout_q;
   assign unused_bits     = btn_s;
`else
   assign timeout_hit     = 1'b0;
   assign bus.req_timeout = 1'b0;
   assign unused_bits     = btn_s ^ (REQ_TIMEOUT > 0);
`endif

   // A press while already pending changes nothing; one during green is
   // dropped because pedestrians are already crossing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_light_q <= PED_RED;
         req_pending <= 1'b0;
      end else begin
         ped_light_q <= bus.ped_light;
         if (serve || timeout_hit) begin
            req_pending <= 1'b0;
         end else if (press && (bus.ped_light == PED_RED)) begin
            req_pending <= 1'b1;
         end
      end
   end

   assign bus.ped_btn     = req_pending;
   assign bus.wait_lamp   = req_pending;
   assign bus.press_pulse = press;
   assign bus.deb_state   = deb_state;

endmodule

// File: tb/tb_ped_btn_conditioner.sv
// Bench for ped_btn_conditioner with DEB_CYCLES=4, REQ_TIMEOUT=8.
// Each vector row is a per-cycle string pattern of inputs and expected outputs;
// cycle i drives its inputs before the i-th rising edge after reset release
// and compares outputs 1 time unit after that edge.
module tb_ped_btn_conditioner;
   import traffic_pkg::*;

   typedef struct {
      string name;
      string btn;
      string light;
      string pulse;
      string req;
      string tmo;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [3:0] exp_q[$];
   logic [3:0] outs;
   vec_t vecs[4];

   ped_btn_conditioner_if bus();

   ped_btn_conditioner #(
      .DEB_CYCLES  (4),
      .REQ_TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign outs = {bus.press_pulse, bus.ped_btn, bus.wait_lamp, bus.req_timeout};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input string b, input string l,
                               input string p, input string r, input string t);
      vec_t v;
      v.name  = n;
      v.btn   = b;
      v.light = l;
      v.pulse = p;
      v.req   = r;
      v.tmo   = t;
      return v;
   endfunction

   function automatic logic bitc(input string s, input int i);
      return s.getc(i) == 8'h31;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic tick(input logic b, input logic l);
      bus.btn_raw   = b;
      bus.ped_light = l;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic raw);
      rst_n         = 1'b0;
      bus.btn_raw   = raw;
      bus.ped_light = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {28'd0, outs}, 32'd0);
      check("reset_state", {30'd0, bus.deb_state}, {30'd0, IDLE});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", {28'd0, outs}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // scoreboard: expectation queued as the cycle is driven, popped after the edge
   task automatic run_row(input vec_t v);
      for (int i = 0; i < v.btn.len(); i++) begin
         exp_q.push_back({bitc(v.pulse, i), bitc(v.req, i), bitc(v.req, i), bitc(v.tmo, i)});
         tick(bitc(v.btn, i), bitc(v.light, i));
         if (exp_q.size() == 0) begin
            check($sformatf("%s[%0d]_queue_empty", v.name, i), 32'd0, 32'd1);
         end else begin
            check($sformatf("%s[%0d]", v.name, i), {28'd0, outs}, {28'd0, exp_q.pop_front()});
         end
      end
   endtask

   initial begin
      int pulses;
      int held;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.btn_raw   = 1'b0;
      bus.ped_light = 1'b0;

      vecs[0] = mk("press_then_serve",
                   "11111111110000000000", "00000000000000111111",
                   "00000100000000000000", "00000011111111000000",
                   "00000000000000000000");
      vecs[1] = mk("bounce_then_stable",
                   "10101111111111111111", "00000000000000001111",
                   "00000000010000000000", "00000000001111110000",
                   "00000000000000000000");
      vecs[2] = mk("pulse_at_serve_and_green_press",
                   "11111100000111111111", "00000011111111111111",
                   "00000100000000001000", "00000000000000000000",
                   "00000000000000000000");
      vecs[3] = mk("short_tap_rejected",
                   "11110000000000000000", "00000000000000000000",
                   "00000000000000000000", "00000000000000000000",
                   "00000000000000000000");

      for (int r = 0; r < 4; r++) begin
         do_reset(1'b1);
         run_row(vecs[r]);
      end

      // Reset while a request is pending discards it.
      do_reset(1'b0);
      run_row(mk("pre_reset", "1111111", "0000000", "0000010", "0000001", "0000000"));
      async_reset();
      run_row(mk("discarded", "00000000", "00000000", "00000000", "00000000", "00000000"));

      // Reset mid-debounce restarts the stability count.
      run_row(mk("partial", "111", "000", "000", "000", "000"));
      async_reset();
      run_row(mk("fresh", "11111111", "00000000", "00000100", "00000011", "00000000"));

`ifdef PED_REQ_TIMEOUT_EN
      do_reset(1'b0);
      run_row(mk("timeout",
                 "111111000000000000", "000000000000000000",
                 "000001000000000000", "000000111111110000",
                 "000000000000001000"));
`else
      // Long hold, bouncy release, second press while pending, then service.
      do_reset(1'b0);
      pulses = 0;
      held   = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1'b1, 1'b0);
         if (bus.press_pulse) pulses++;
         if (i >= 6 && bus.ped_btn && bus.wait_lamp) held++;
      end
      for (int i = 0; i < 16; i++) begin
         tick((i == 1) || (i == 3), 1'b0);
         if (bus.press_pulse) pulses++;
         if (bus.ped_btn && bus.wait_lamp) held++;
      end
      check("hold_single_pulse", pulses, 32'd1);
      check("hold_level_kept", held, 32'd110);
      pulses = 0;
      held   = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, 1'b0);
         if (bus.press_pulse) pulses++;
         if (bus.ped_btn) held++;
      end
      check("repress_pulse", pulses, 32'd1);
      check("repress_no_change", held, 32'd8);
      tick(1'b1, 1'b1);
      check("served_clear", {28'd0, outs}, 32'd0);
      tick(1'b1, 1'b1);
      check("served_stays_clear", {28'd0, outs}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
